frame_rx_fsm: RTL

- Receive-side frame parser for the DCFEB optical frame link; it is the far-end counterpart of the frame transmit sequencer.
- The transmitter emits this frame: SOP, three preamble words, SOF, data words, two CRC words, EOP.
- This block hunts for SOP, checks the preamble and SOF, and strips the CRC words using a 2-word delay line.
- It forwards data words with first/last flags, checks the CRC-32, and reports a per-frame status to downstream logic.

---
 rtl/frame_link_pkg.sv | 23 ++
 rtl/frame_rx_fsm_if.sv | 28 ++
 rtl/crc32_d16.sv | 19 +
 rtl/frame_rx_fsm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/frame_link_pkg.sv
// rtl/frame_link_pkg.sv - shared frame link state encodings, symbols and CRC constants
package frame_link_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SOF   = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4
  } frame_state_t;

  localparam logic [15:0] SOP_SYM  = 16'h50FB;
  localparam logic [15:0] EOP_SYM  = 16'h50FD;
  localparam logic [15:0] PRE_WORD = 16'h5555;
  localparam logic [15:0] SOF_WORD = 16'hD555;

  localparam logic [1:0]  K_NONE   = 2'b00;
  localparam logic [1:0]  K_CTRL   = 2'b01;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/frame_rx_fsm_if.sv
// rtl/frame_rx_fsm_if.sv - receive word stream in, parsed data and frame status out
// Signals: RX_DATA/RX_K/RX_VLD (link side), DOUT/DOUT_VLD/DOUT_FIRST/DOUT_LAST,
//          CRC_OK/CRC_ERR/FRM_ERR, WORD_CNT, FRM_STATE (parser side).
// master: link source and status consumer; slave: the parser.
interface frame_rx_fsm_if;
  logic [15:0] RX_DATA;
  logic [1:0]  RX_K;
  logic        RX_VLD;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic        DOUT_FIRST;
  logic        DOUT_LAST;
  logic        CRC_OK;
  logic        CRC_ERR;
  logic        FRM_ERR;
  logic [10:0] WORD_CNT;
  logic [2:0]  FRM_STATE;

  modport master (
    output RX_DATA, RX_K, RX_VLD,
    input  DOUT, DOUT_VLD, DOUT_FIRST, DOUT_LAST, CRC_OK, CRC_ERR, FRM_ERR, WORD_CNT, FRM_STATE
  );

  modport slave (
    input  RX_DATA, RX_K, RX_VLD,
    output DOUT, DOUT_VLD, DOUT_FIRST, DOUT_LAST, CRC_OK, CRC_ERR, FRM_ERR, WORD_CNT, FRM_STATE
  );
endinterface

// File: rtl/crc32_d16.sv
// rtl/crc32_d16.sv - combinational CRC-32 update, 16 data bits per step, MSB first
// Ports: i_crc (current CRC), i_data (16-bit word), o_crc (next CRC). No final inversion.
module crc32_d16
  import frame_link_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [15:0] i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = i_crc;
    for (int i = 15; i >= 0; i--) begin
      if (o_crc[31] ^ i_data[i]) o_crc = {o_crc[30:0], 1'b0} ^ CRC_POLY;
      else                       o_crc = {o_crc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/frame_rx_fsm.sv
// rtl/frame_rx_fsm.sv - receive-side frame parser: SOP hunt, preamble/SOF check, CRC strip and check
// Ports: CLK, RST_N (asynchronous active-low), bus (frame_rx_fsm_if.slave).
//        In: RX_DATA, RX_K, RX_VLD. Out (all registered): DOUT, DOUT_VLD, DOUT_FIRST, DOUT_LAST,
//        CRC_OK, CRC_ERR, FRM_ERR pulses, WORD_CNT of last completed frame, FRM_STATE.
module frame_rx_fsm
  import frame_link_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input logic           CLK,
  input logic           RST_N,
  frame_rx_fsm_if.slave bus
);

  localparam logic [10:0] CNT_MAX = 11'(MAX_WORDS);
  localparam logic [10:0] CNT_SAT = 11'(MAX_WORDS + 1);

  frame_state_t r_state;
  logic [1:0]   r_pre_cnt;
  logic [1:0]   r_fill;       // words currently held in the d0/d1 delay line
  logic [15:0]  r_d0, r_d1;   // d0 newest; at EOP these are the received CRC words
  logic [15:0]  r_hold;       // last word pushed out of d1, waiting to learn if it is the final one
  logic [10:0]  r_cnt;        // data words pushed out of the delay line this frame
  logic [31:0]  r_crc;
  logic [15:0]  r_dout;
  logic         r_dout_vld, r_dout_first, r_dout_last;
  logic         r_crc_ok, r_crc_err, r_frm_err;
  logic [10:0]  r_word_cnt;

  logic [31:0]  w_crc_next;
  logic         w_is_data, w_is_sop, w_is_eop, w_crc_match;

  assign w_is_data   = (bus.RX_K == K_NONE);
  assign w_is_sop    = (bus.RX_K == K_CTRL) && (bus.RX_DATA == SOP_SYM);
  assign w_is_eop    = (bus.RX_K == K_CTRL) && (bus.RX_DATA == EOP_SYM);
  assign w_crc_match = (r_crc == {r_d1, r_d0});

  crc32_d16 u_crc (
    .i_crc  (r_crc),
    .i_data (r_d1),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_HUNT;
      r_pre_cnt    <= 2'd0;
      r_fill       <= 2'd0;
      r_d0         <= 16'd0;
      r_d1         <= 16'd0;
      r_hold       <= 16'd0;
      r_cnt        <= 11'd0;
      r_crc        <= 32'd0;
      r_dout       <= 16'd0;
      r_dout_vld   <= 1'b0;
      r_dout_first <= 1'b0;
      r_dout_last  <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_crc_err    <= 1'b0;
      r_frm_err    <= 1'b0;
      r_word_cnt   <= 11'd0;
    end else begin
      // Strobes and pulses are single-cycle; DOUT keeps its last value between strobes.
      r_dout_vld   <= 1'b0;
      r_dout_first <= 1'b0;
      r_dout_last  <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_crc_err    <= 1'b0;
      r_frm_err    <= 1'b0;

      case (r_state)
        ST_CHECK: begin
          // Runs regardless of RX_VLD; a word arriving here is dropped.
          r_crc_ok   <= w_crc_match;
          r_crc_err  <= !w_crc_match;
          r_word_cnt <= r_cnt;
          r_state    <= ST_HUNT;
        end

        default: begin
          if (bus.RX_VLD) begin
            case (r_state)
              ST_HUNT: begin
                if (w_is_sop) begin
                  r_state   <= ST_PRE;
                  r_pre_cnt <= 2'd0;
                end
              end

              ST_PRE: begin
                if (w_is_data && bus.RX_DATA == PRE_WORD) begin
                  if (r_pre_cnt == 2'd2) r_state <= ST_SOF;
                  else                   r_pre_cnt <= r_pre_cnt + 2'd1;
                end else begin
                  r_frm_err <= 1'b1;
                  r_state   <= ST_HUNT;
                end
              end

              ST_SOF: begin
                if (w_is_data && bus.RX_DATA == SOF_WORD) begin
                  r_state <= ST_DATA;
                  r_crc   <= CRC_INIT;
                  r_fill  <= 2'd0;
                  r_cnt   <= 11'd0;
                end else begin
                  r_frm_err <= 1'b1;
                  r_state   <= ST_HUNT;
                end
              end

              ST_DATA: begin
                if (w_is_data) begin
                  r_d0 <= bus.RX_DATA;
                  r_d1 <= r_d0;
                  if (r_fill == 2'd2) begin
                    // d1 is now known to be payload: fold it, park it, and release the
                    // previously parked word (which is therefore not the last one).
                    r_crc  <= w_crc_next;
                    r_hold <= r_d1;
                    if (r_cnt != 11'd0) begin
                      r_dout       <= r_hold;
                      r_dout_vld   <= 1'b1;
                      r_dout_first <= (r_cnt == 11'd1);
                    end
                    if (r_cnt == CNT_MAX) begin
                      r_cnt     <= CNT_SAT;
                      r_frm_err <= 1'b1;
                      r_state   <= ST_HUNT;
                    end else begin
                      r_cnt <= r_cnt + 11'd1;
                    end
                  end else begin
                    r_fill <= r_fill + 2'd1;
                  end
                end else if (w_is_eop) begin
                  if (r_cnt == 11'd0) begin
                    r_frm_err <= 1'b1;
                    r_state   <= ST_HUNT;
                  end else begin
                    r_dout       <= r_hold;
                    r_dout_vld   <= 1'b1;
                    r_dout_first <= (r_cnt == 11'd1);
                    r_dout_last  <= 1'b1;
                    r_state      <= ST_CHECK;
                  end
                end else begin
                  r_frm_err <= 1'b1;
                  r_state   <= ST_HUNT;
                end
              end

              default: r_state <= ST_HUNT;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.DOUT       = r_dout;
  assign bus.DOUT_VLD   = r_dout_vld;
  assign bus.DOUT_FIRST = r_dout_first;
  assign bus.DOUT_LAST  = r_dout_last;
  assign bus.CRC_OK     = r_crc_ok;
  assign bus.CRC_ERR    = r_crc_err;
  assign bus.FRM_ERR    = r_frm_err;
  assign bus.WORD_CNT   = r_word_cnt;
  assign bus.FRM_STATE  = r_state;

endmodule
